// File: rtl/csr_row_streamer_if.sv
// Handshake bundle for csr_row_streamer: matrix load side and beat stream side.
// The producer/consumer holds master; the streamer holds slave.
interface csr_row_streamer_if #(
    parameter int IN_SIZE    = 8,
    parameter int FETCH_SIZE = 2,
    parameter int NUM_ROWS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]    in_data;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    in_index;
    logic [NUM_ROWS:0][ADDR_WIDTH-1:0]     in_bounds;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [FETCH_SIZE-1:0][DATA_WIDTH-1:0] out_data;
    logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] out_index;
    logic [FETCH_SIZE-1:0]                 out_mask;
    logic [ADDR_WIDTH-1:0]                 out_row;
    logic                                  out_row_last;
    logic                                  out_last;
    logic                                  out_valid;
    logic                                  out_ready;

    modport master (
        output in_data, in_index, in_bounds, in_valid, out_ready,
        input  in_ready, out_data, out_index, out_mask, out_row,
        input  out_row_last, out_last, out_valid
    );

    modport slave (
        input  in_data, in_index, in_bounds, in_valid, out_ready,
        output in_ready, out_data, out_index, out_mask, out_row,
        output out_row_last, out_last, out_valid
    );
endinterface

// File: rtl/csr_row_streamer.sv
// Latches one CSR matrix, then streams its rows as FETCH_SIZE-wide beats.
// Optional CSR_SKIP_EMPTY_ROWS_EN: empty rows emit no beat.
module csr_row_streamer #(
    parameter int IN_SIZE    = 8,
    parameter int FETCH_SIZE = 2,
    parameter int NUM_ROWS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    csr_row_streamer_if.slave  bus
);
    localparam int RW = $clog2(NUM_ROWS + 1);
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int XW = ADDR_WIDTH + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_q, state_d;
    logic   accept, load;

    logic [IN_SIZE-1:0][DATA_WIDTH-1:0] data_q;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0] index_q;
    logic [NUM_ROWS:0][ADDR_WIDTH-1:0]  bounds_q;
    logic [RW-1:0]                      row_q, row_nx;
    logic [ADDR_WIDTH-1:0]              off_q;
    logic                               gen_done_q;

    logic [ADDR_WIDTH-1:0] lo, hi, hi_eff;
    logic                  empty, row_end, row_final;
    logic                  beat_last, skip_row;
    logic [XW-1:0]         step_end;
    logic [XW-1:0]         lane_addr [FETCH_SIZE];

    logic [FETCH_SIZE-1:0][DATA_WIDTH-1:0] lane_data;
    logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] lane_index;
    logic [FETCH_SIZE-1:0]                 lane_mask;

`ifdef CSR_SKIP_EMPTY_ROWS_EN
    logic [RW-1:0] last_ne_q, last_ne_d;
    logic          any_ne_q, any_ne_d;

    always_comb begin
        last_ne_d = '0;
        any_ne_d  = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bus.in_bounds[r+1] > bus.in_bounds[r]) begin
                last_ne_d = RW'(r);
                any_ne_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ne_q <= '0;
            any_ne_q  <= 1'b0;
        end else if (accept) begin
            last_ne_q <= last_ne_d;
            any_ne_q  <= any_ne_d;
        end
    end

    // An all-empty matrix still emits one beat on the final row.
    always_comb begin
        if (any_ne_q) begin
            row_final = (row_q == last_ne_q);
            skip_row  = empty;
        end else begin
            row_final = (row_q == RW'(NUM_ROWS - 1));
            skip_row  = empty && !row_final;
        end
    end
`else
    always_comb begin
        row_final = (row_q == RW'(NUM_ROWS - 1));
        skip_row  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (bus.in_valid) state_d = STREAM;
            STREAM:
                if (bus.out_valid && bus.out_ready && bus.out_last)
                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
        accept       = bus.in_valid && (state_q == IDLE);
        load         = (state_q == STREAM)
                    && (!bus.out_valid || bus.out_ready);
    end

    // Reversed bounds collapse to an empty row at the lower pointer.
    always_comb begin
        row_nx    = row_q + RW'(1);
        lo        = bounds_q[row_q];
        hi        = bounds_q[row_nx];
        empty     = (hi <= lo);
        hi_eff    = empty ? lo : hi;
        step_end  = {1'b0, off_q} + XW'(FETCH_SIZE);
        row_end   = (step_end >= {1'b0, hi_eff});
        beat_last = row_end && row_final;
        for (int i = 0; i < FETCH_SIZE; i++) begin
            lane_addr[i]  = {1'b0, off_q} + XW'(i);
            lane_mask[i]  = (lane_addr[i] < {1'b0, hi})
                         && (lane_addr[i] < XW'(IN_SIZE));
            lane_data[i]  = '0;
            lane_index[i] = '1;
            if (lane_mask[i]) begin
                lane_data[i]  = data_q[lane_addr[i][IW-1:0]];
                lane_index[i] = index_q[lane_addr[i][IW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q           <= '0;
            index_q          <= '0;
            bounds_q         <= '0;
            row_q            <= '0;
            off_q            <= '0;
            gen_done_q       <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_index    <= '1;
            bus.out_mask     <= '0;
            bus.out_row      <= '0;
            bus.out_row_last <= 1'b0;
            bus.out_last     <= 1'b0;
        end else if (accept) begin
            data_q     <= bus.in_data;
            index_q    <= bus.in_index;
            bounds_q   <= bus.in_bounds;
            row_q      <= '0;
            off_q      <= bus.in_bounds[0];
            gen_done_q <= 1'b0;
        end else if (load) begin
            if (gen_done_q) begin
                bus.out_valid <= 1'b0;
            end else if (skip_row) begin
                bus.out_valid <= 1'b0;
                row_q         <= row_nx;
                off_q         <= hi;
            end else begin
                bus.out_valid    <= 1'b1;
                bus.out_data     <= lane_data;
                bus.out_index    <= lane_index;
                bus.out_mask     <= lane_mask;
                bus.out_row      <= ADDR_WIDTH'(row_q);
                bus.out_row_last <= row_end;
                bus.out_last     <= beat_last;
                if (beat_last) begin
                    gen_done_q <= 1'b1;
                end else if (row_end) begin
                    row_q <= row_nx;
                    off_q <= hi;
                end else begin
                    off_q <= off_q + ADDR_WIDTH'(FETCH_SIZE);
                end
            end
        end
    end
endmodule

// File: doc/csr_row_streamer.md
Name: csr_row_streamer

Overview:
- Sequential successor to the combinational CSR row fetcher.
- Accepts one whole CSR matrix (values, column indices, row bounds) on a valid/ready handshake and latches it.
- Then streams every row, in order, as FETCH_SIZE-wide beats on a valid/ready output. Rows longer than FETCH_SIZE are split across several beats.
- Sits between the sparse matrix buffer and the sparse MAC/row consumers.

Parameters:
- IN_SIZE, 8: number of stored nonzeros (length of in_data and in_index).
- FETCH_SIZE, 2: number of elements per output beat.
- NUM_ROWS, 4: number of rows; in_bounds has NUM_ROWS+1 entries.
- DATA_WIDTH, 16: width of each value.
- ADDR_WIDTH, 16: width of indices, bounds and row ids.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- in_data  in  DATA_WIDTH x IN_SIZE  nonzero values.
- in_index  in  ADDR_WIDTH x IN_SIZE  column index of each value.
- in_bounds  in  ADDR_WIDTH x (NUM_ROWS+1)  CSR row pointers.
- in_valid  in  1  matrix presented.
- in_ready  out  1  block can accept a matrix.
- out_data  out  DATA_WIDTH x FETCH_SIZE  beat values.
- out_index  out  ADDR_WIDTH x FETCH_SIZE  beat column indices; all-ones in unused lanes.
- out_mask  out  FETCH_SIZE  per-lane valid.
- out_row  out  ADDR_WIDTH  row id of the beat.
- out_row_last  out  1  last beat of the current row.
- out_last  out  1  last beat of the matrix.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset, asynchronous, while rst=0:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_mask=0, out_data=0, out_index=all-ones.
  - out_row=0, out_row_last=0, out_last=0.
  - Internal row and offset counters are cleared.
  - Asserting rst mid-stream aborts the matrix; nothing is resumed.
- States: IDLE and STREAM.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all inputs, set row=0 and offset=in_bounds[0], then go to STREAM.
- STREAM:
  - in_ready=0.
  - The output register loads the next beat whenever !out_valid || out_ready.
  - Throughput is one beat per cycle under continuous out_ready.
  - First beat: out_valid rises on the first clk edge after the accepting edge, i.e. 1 cycle latency.
- Row length:
  - len = bounds[r+1]-bounds[r], as an unsigned subtract.
  - If bounds[r+1]<bounds[r], len is treated as 0.
- Beat count per row:
  - ceil(len/FETCH_SIZE) beats.
  - An empty row yields exactly one beat with out_mask=0, data 0, index all-ones (optional feature excepted).
- Lane i of a beat:
  - addr = offset+i.
  - Lane is valid iff addr < bounds[r+1] and addr < IN_SIZE.
  - Invalid lanes output data 0 and index all-ones.
- After each accepted beat:
  - offset += FETCH_SIZE.
  - When the row is exhausted, set out_row_last=1 on that beat, advance to r+1, and set offset=bounds[r+1].
- Matrix end:
  - out_last=1 on the final beat of row NUM_ROWS-1; out_row_last is also 1 on that beat.
  - When that beat is accepted: out_valid=0 and state returns to IDLE.
  - in_ready=1 from the next cycle; there is no back-to-back overlap.
- Backpressure: while out_valid&&!out_ready, every out_* signal holds stable.
- in_valid is ignored while in STREAM.
- bounds[0] is honoured as the base pointer; it is not required to be 0.

Optional Feature:
- Macro: CSR_SKIP_EMPTY_ROWS_EN.
- Defined:
  - Rows with len=0 emit no beat.
  - out_last is placed on the last beat of the last nonempty row, which is recorded at accept time.
  - If every row is empty, exactly one beat is emitted: out_mask=0, out_row=NUM_ROWS-1, out_row_last=1, out_last=1.
- Undefined: every row emits at least one beat, as described in Behaviour.

Test Plan:
- Basic stream, out_ready=1:
  - Stimulus: bounds={0,2,3,3,6}, data=10..15, index={1,3,0,0,2,3}, FETCH_SIZE=2.
  - Beats in order:
    - row0 {10,11} mask 11, out_row_last=1.
    - row1 {12,-} mask 01, out_row_last=1.
    - row2 mask 00, out_row_last=1.
    - row3 {13,14} mask 11, out_row_last=0.
    - row3 {15,-} mask 01, out_row_last=1, out_last=1.
  - First out_valid is 1 cycle after accept.
- Backpressure:
  - Stimulus: same matrix, out_ready toggled 1,0,0,1,...
  - Outputs are stable while stalled; the same 5 beats arrive in order; in_ready=1 only after the final accept.
- Reset mid-stream:
  - Stimulus: drive rst=0 after beat 2.
  - out_valid=0 and in_ready=1 immediately (asynchronously).
  - A new matrix with bounds={4,5,5,5,5} then streams row0 = in_data[4] first.
- Malformed bounds:
  - Stimulus: bounds={0,3,1,9,9} with IN_SIZE=8.
  - row1 is treated as empty.
  - row2 covers addresses 1..8; address 8 is masked off because 8 ≥ IN_SIZE.
  - No X on any output.
- With CSR_SKIP_EMPTY_ROWS_EN:
  - Stimulus 1: bounds={0,2,2,3,3}. Beats are row0 (mask 11) then row2 (mask 01, out_last=1). Total 2 beats.
  - Stimulus 2: bounds all 0. Exactly one beat: mask 00, out_row=3, out_last=1.
